i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL provide parameter TIMEOUT, default 65535, max cycles waiting on master per phase (1..65535).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, ports as follows:
REQ-004 CLK_IW  input  1  single clock, all logic on rising edge.
REQ-005 RST_IW  input  1  asynchronous active-low reset.
REQ-006 REQ_IW  input  NUM_REQ  per-requester transfer request, level.
REQ-007 ADDR_IW  input  7*NUM_REQ  requester i address at bits [7i+6:7i].
REQ-008 DATA_IW  input  8*NUM_REQ  requester i data at bits [8i+7:8i].
REQ-009 ACK_OW  output  NUM_REQ  one-cycle pulse: request i accepted, operands latched.
REQ-010 DONE_OW  output  NUM_REQ  one-cycle pulse: transfer for i completed.
REQ-011 GRANT_OW  output  NUM_REQ  one-hot owner of master, zero when idle.
REQ-012 M_START_OW  output  1  start strobe to I2C master.
REQ-013 M_ADDR_OW  output  7  latched address to master.
REQ-014 M_DATA_OW  output  8  latched data to master.
REQ-015 M_READY_IW  input  1  master ready (high = idle).
REQ-016 ERR_OW  output  1  one-cycle pulse on timeout.
REQ-017 BUSY_OW  output  1  high whenever state != IDLE.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
REQ-019 IDLE: when M_READY_IW=1 and REQ_IW!=0, SHALL pick winner by round-robin, searching from last_served+1 upward with wrap at NUM_REQ.
REQ-020 On pick, same edge SHALL latch winner's ADDR/DATA into M_ADDR_OW/M_DATA_OW, set GRANT_OW one-hot, pulse ACK_OW[winner] next cycle, go ISSUE.
REQ-021 IDLE with M_READY_IW=0 SHALL not grant regardless of REQ_IW.
REQ-022 ISSUE: M_START_OW SHALL be high exactly one cycle (the ISSUE cycle), then go WAIT_LOW.
REQ-023 WAIT_LOW: on M_READY_IW=0 go WAIT_HIGH; WAIT_HIGH: on M_READY_IW=1 pulse DONE_OW[owner], set last_served=owner, clear GRANT_OW, go IDLE.
REQ-024 Earliest new grant SHALL be the cycle after DONE_OW; ACK-to-next-ACK minimum 4 cycles plus master busy time.
REQ-025 Timeout counter SHALL clear on entry to WAIT_LOW and WAIT_HIGH, count each cycle in those states; reaching TIMEOUT SHALL pulse ERR_OW, set last_served=owner, clear GRANT_OW, go IDLE, no DONE_OW.
REQ-026 M_ADDR_OW/M_DATA_OW SHALL hold stable from latch until next grant; input changes after ACK SHALL be ignored.
REQ-027 REQ_IW deasserted before ACK SHALL withdraw request with no side effects; REQ_IW held after ACK SHALL be treated as a new request.
REQ-028 Simultaneous requests SHALL be served fairly: each active requester served at most once per NUM_REQ grants while others wait.
REQ-029 At most one bit of ACK_OW, DONE_OW, GRANT_OW SHALL be high in any cycle; ACK and DONE never same cycle.

Reset
REQ-030 RST_IW low SHALL immediately force state IDLE and all outputs 0, including mid-transfer M_START_OW.
REQ-031 Reset SHALL set last_served=NUM_REQ-1 so requester 0 has first priority, and clear timeout counter.
REQ-032 First grant possible on first rising edge after RST_IW deasserts.

Verification
REQ-033 Single: REQ_IW=0001, ADDR0=0x3C, DATA0=0xA5, master idle -> ACK_OW=0001, one M_START_OW with 0x3C/0xA5, DONE_OW=0001 after M_READY_IW low-then-high.
REQ-034 Contention: REQ_IW=1111 held, fast master model -> ACK order 0,1,2,3,0; GRANT_OW always one-hot.
REQ-035 Not-ready: M_READY_IW=0, REQ_IW=0010 -> no ACK/START; raise M_READY_IW -> ACK_OW=0010 next cycle.
REQ-036 Timeout (TIMEOUT=16): grant req 2, hold M_READY_IW=1 -> ERR_OW pulse 16 cycles after WAIT_LOW entry, no DONE, BUSY_OW=0 after.
REQ-037 Reset mid-transfer in WAIT_HIGH -> all outputs 0 asynchronously; after release REQ_IW=1111 -> requester 0 granted first.
REQ-038 Input hold: change ADDR0/DATA0 after ACK -> M_ADDR_OW/M_DATA_OW unchanged through DONE.

Source files
------------

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter that shares one I2C master between
// NUM_REQ requesters. It latches the winner's address and data, issues a
// single start strobe, follows the master's ready handshake (low, then high)
// and reports completion, or an error if the master stalls past TIMEOUT.
//
// Ports
//   CLK_IW, RST_IW          clock, asynchronous active-low reset
//   REQ_IW                  per-requester level request
//   ADDR_IW / DATA_IW       packed per-requester address (7b) / data (8b)
//   ACK_OW / DONE_OW        one-cycle accept / completion pulses (one-hot)
//   GRANT_OW                one-hot owner of the master, zero when idle
//   M_START_OW, M_ADDR_OW,
//   M_DATA_OW, M_READY_IW   I2C master handshake
//   ERR_OW                  one-cycle pulse when the master times out
//   BUSY_OW                 high whenever the arbiter is not idle
module i2c_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                   CLK_IW,
  input  logic                   RST_IW,
  input  logic [NUM_REQ-1:0]     REQ_IW,
  input  logic [7*NUM_REQ-1:0]   ADDR_IW,
  input  logic [8*NUM_REQ-1:0]   DATA_IW,
  output logic [NUM_REQ-1:0]     ACK_OW,
  output logic [NUM_REQ-1:0]     DONE_OW,
  output logic [NUM_REQ-1:0]     GRANT_OW,
  output logic                   M_START_OW,
  output logic [6:0]             M_ADDR_OW,
  output logic [7:0]             M_DATA_OW,
  input  logic                   M_READY_IW,
  output logic                   ERR_OW,
  output logic                   BUSY_OW
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 start_q, start_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;
  logic [NUM_REQ-1:0]   win_oh;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_data;
  logic                 timeout_hit;

  // Round-robin search starting just above the last served requester.
  always_comb begin : rr_pick
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % NUM_REQ);
      if (!win_found && REQ_IW[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_oh   = NUM_REQ'(1) << win_idx;
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_addr = ADDR_IW[ADDR_W*i +: ADDR_W];
        win_data = DATA_IW[DATA_W*i +: DATA_W];
      end
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (M_READY_IW && win_found) begin
          state_d = ISSUE;
          owner_d = win_idx;
          grant_d = win_oh;
          ack_d   = win_oh;
          start_d = 1'b1;
          addr_d  = win_addr;
          data_d  = win_data;
        end
      end
      ISSUE: begin
        state_d = WAIT_LOW;
        cnt_d   = '0;
      end
      WAIT_LOW: begin
        if (!M_READY_IW) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
          last_d  = owner_q;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (M_READY_IW) begin
          state_d = IDLE;
          done_d  = grant_q;
          last_d  = owner_q;
          grant_d = '0;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
          last_d  = owner_q;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset gives requester 0 first priority.
  always_ff @(posedge CLK_IW or negedge RST_IW) begin
    if (!RST_IW) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      grant_q <= '0;
      start_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      grant_q <= grant_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign ACK_OW     = ack_q;
  assign DONE_OW    = done_q;
  assign GRANT_OW   = grant_q;
  assign M_START_OW = start_q;
  assign M_ADDR_OW  = addr_q;
  assign M_DATA_OW  = data_q;
  assign ERR_OW     = err_q;
  assign BUSY_OW    = busy_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Testbench for i2c_arbiter: per-cycle vector table (single transfer,
// withdrawn request, master not ready, four-way contention) followed by
// hand-written sequences for timeout, asynchronous reset and operand hold.
module tb_i2c_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [27:0] addr;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic [3:0]  grant;
  logic        m_start;
  logic [6:0]  m_addr;
  logic [7:0]  m_data;
  logic        m_ready;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  i2c_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .CLK_IW     (clk),
    .RST_IW     (rst_n),
    .REQ_IW     (req),
    .ADDR_IW    (addr),
    .DATA_IW    (data),
    .ACK_OW     (ack),
    .DONE_OW    (done),
    .GRANT_OW   (grant),
    .M_START_OW (m_start),
    .M_ADDR_OW  (m_addr),
    .M_DATA_OW  (m_data),
    .M_READY_IW (m_ready),
    .ERR_OW     (err),
    .BUSY_OW    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] ack;
    logic [3:0] grant;
    logic       start;
    logic [3:0] done;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, logic [3:0] rq, logic rdy, logic [3:0] ak,
                              logic [3:0] gr, logic st, logic [3:0] dn, logic bz);
    vec_t v;
    v.rst = rst; v.req = rq; v.rdy = rdy; v.ack = ak;
    v.grant = gr; v.start = st; v.done = dn; v.busy = bz;
    return v;
  endfunction

  function automatic logic [6:0] base_addr(int i);
    return (i == 0) ? 7'h3C : 7'(7'h10 + i);
  endfunction

  function automatic logic [7:0] base_data(int i);
    return (i == 0) ? 8'hA5 : 8'(8'h50 + i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ack"},   32'(ack),     0);
    chk({nm, "_done"},  32'(done),    0);
    chk({nm, "_grant"}, 32'(grant),   0);
    chk({nm, "_start"}, 32'(m_start), 0);
    chk({nm, "_addr"},  32'(m_addr),  0);
    chk({nm, "_data"},  32'(m_data),  0);
    chk({nm, "_err"},   32'(err),     0);
    chk({nm, "_busy"},  32'(busy),    0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic load_operands();
    for (int i = 0; i < 4; i++) begin
      addr[7*i +: 7] = base_addr(i);
      data[8*i +: 8] = base_data(i);
    end
  endtask

  initial begin
    int n;
    int own;
    logic [3:0] oh;
    rst_n   = 1'b0;
    req     = '0;
    m_ready = 1'b1;
    addr    = '0;
    data    = '0;
    load_operands();

    // Single transfer, withdrawn request, master-not-ready.
    vecs.push_back(mk(1, 4'b0001, 1, 4'b0001, 4'b0001, 1, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 4'b0001, 0, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0001, 0, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0001, 0, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0010, 1, 4'b0010, 4'b0010, 1, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 4'b0010, 0, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0010, 0, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 4'b0010, 0));
    // Contention from reset: all four held, fast master; order 0,1,2,3,0.
    for (int t = 0; t < 5; t++) begin
      oh = 4'b0001 << (t % 4);
      vecs.push_back(mk(t == 0, 4'hF, 1, oh,      oh,      1, 4'b0000, 1));
      vecs.push_back(mk(0,      4'hF, 0, 4'b0000, oh,      0, 4'b0000, 1));
      vecs.push_back(mk(0,      4'hF, 0, 4'b0000, oh,      0, 4'b0000, 1));
      vecs.push_back(mk(0,      4'hF, 1, 4'b0000, 4'b0000, 0, oh,      0));
    end

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      req     = vecs[i].req;
      m_ready = vecs[i].rdy;
      step();
      chk($sformatf("row%0d_ack", i),   32'(ack),     32'(vecs[i].ack));
      chk($sformatf("row%0d_grant", i), 32'(grant),   32'(vecs[i].grant));
      chk($sformatf("row%0d_start", i), 32'(m_start), 32'(vecs[i].start));
      chk($sformatf("row%0d_done", i),  32'(done),    32'(vecs[i].done));
      chk($sformatf("row%0d_err", i),   32'(err),     0);
      chk($sformatf("row%0d_busy", i),  32'(busy),    32'(vecs[i].busy));
      if (vecs[i].start) begin
        own = 0;
        for (int j = 0; j < 4; j++) if (vecs[i].grant[j]) own = j;
        chk($sformatf("row%0d_maddr", i), 32'(m_addr), 32'(base_addr(own)));
        chk($sformatf("row%0d_mdata", i), 32'(m_data), 32'(base_data(own)));
      end
    end

    // Timeout: grant requester 2, master never drops ready.
    do_reset();
    req = 4'b0100;
    m_ready = 1'b1;
    step();
    chk("to_ack", 32'(ack), 32'h4);
    req = 4'b0000;
    step();
    chk("to_wait_busy", 32'(busy), 1);
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("to_latency", n, 16);
    chk("to_no_done", 32'(done), 0);
    chk("to_grant_clr", 32'(grant), 0);
    chk("to_busy_clr", 32'(busy), 0);
    step();
    chk("to_err_pulse", 32'(err), 0);

    // After the timeout requester 2 counts as served, so 3 wins next.
    req = 4'hF;
    step();
    chk("post_to_grant", 32'(grant), 32'h8);
    m_ready = 1'b0;
    step();
    step();
    chk("wh_busy", 32'(busy), 1);
    // Asynchronous reset while waiting for the master to finish.
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst_wh");
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    step();
    chk("rst_first_grant", 32'(grant), 32'h1);
    chk("rst_first_start", 32'(m_start), 1);
    // Reset during the start strobe must drop it immediately.
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst_issue");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Operand hold: inputs change after ACK, latched values must not.
    req = 4'b0001;
    m_ready = 1'b1;
    step();
    chk("hold_ack", 32'(ack), 32'h1);
    req = 4'b0000;
    addr[6:0] = 7'h55;
    data[7:0] = 8'h12;
    m_ready = 1'b0;
    step();
    chk("hold_addr_wl", 32'(m_addr), 32'h3C);
    chk("hold_data_wl", 32'(m_data), 32'hA5);
    step();
    m_ready = 1'b1;
    step();
    chk("hold_done", 32'(done), 32'h1);
    chk("hold_addr_done", 32'(m_addr), 32'h3C);
    chk("hold_data_done", 32'(m_data), 32'hA5);
    load_operands();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
